// File: rtl/run_det_pkg.sv
// Shared types and constants for the serial run detector.
package run_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        MATCH = 2'd2
    } state_e;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ONES  = 2'b01;
    localparam logic [1:0] MODE_ZEROS = 2'b10;
    localparam logic [1:0] MODE_BOTH  = 2'b11;

    // True when the given bit value is one of the polarities selected by mode.
    function automatic logic pol_ok(input logic bit_v, input logic [1:0] mode_v);
        if (bit_v) begin
            return (mode_v & MODE_ONES) != MODE_OFF;
        end
        return (mode_v & MODE_ZEROS) != MODE_OFF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. clr wins over inc; clr together with inc restarts the count at 1.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = inc ? W'(1) : '0;
        end else if (inc && (q_q != MAX)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/run_length_detector.sv
// Serial run detector: flags RUN_LEN identical qualified samples of a selected polarity.
// Define RUN_DET_STICKY_EN to make led hold once set until rst or clear.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             signal,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             led,
    output logic             match_val,
    output logic [CNT_W-1:0] det_cnt
);

    localparam int            RC_W     = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0] RUN_MAX  = RC_W'(RUN_LEN);
    localparam logic [RC_W-1:0] RUN_LAST = RC_W'(RUN_LEN - 1);

    state_e          state_q, state_d;
    logic            last_bit_q, last_bit_d;
    logic            led_q, led_d;
    logic            match_val_q, match_val_d;
    logic [RC_W-1:0] run_cnt_q;
    logic            run_inc, run_clr;
    logic            det_inc, det_clr;
    logic            enter_match;
    logic            pol;
    logic            led_plain;

    sat_counter #(.W(RC_W), .MAX(RUN_MAX)) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .inc (run_inc),
        .clr (run_clr),
        .q   (run_cnt_q)
    );

    sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_det_cnt (
        .clk (clk),
        .rst (rst),
        .inc (det_inc),
        .clr (det_clr),
        .q   (det_cnt)
    );

    always_comb begin
        state_d     = state_q;
        last_bit_d  = last_bit_q;
        led_d       = led_q;
        match_val_d = match_val_q;
        run_inc     = 1'b0;
        run_clr     = 1'b0;
        det_inc     = 1'b0;
        det_clr     = 1'b0;
        enter_match = 1'b0;
        pol         = 1'b0;
        led_plain   = 1'b0;
        if (clear) begin
            state_d     = IDLE;
            last_bit_d  = 1'b0;
            led_d       = 1'b0;
            match_val_d = 1'b0;
            run_clr     = 1'b1;
            det_clr     = 1'b1;
        end else if (en) begin
            case (state_q)
                COUNT: begin
                    if (signal == last_bit_q) begin
                        run_inc = 1'b1;
                        if (run_cnt_q == RUN_LAST) begin
                            state_d     = MATCH;
                            enter_match = 1'b1;
                        end
                    end else begin
                        last_bit_d = signal;
                        run_clr    = 1'b1;
                        run_inc    = 1'b1;
                    end
                end
                MATCH: begin
                    if (signal == last_bit_q) begin
                        run_inc = 1'b1;
                    end else begin
                        last_bit_d = signal;
                        run_clr    = 1'b1;
                        run_inc    = 1'b1;
                        state_d    = COUNT;
                    end
                end
                default: begin
                    last_bit_d = signal;
                    run_clr    = 1'b1;
                    run_inc    = 1'b1;
                    state_d    = COUNT;
                end
            endcase

            pol = pol_ok(last_bit_d, mode);
            // Staying in MATCH only keeps an already-lit led; it never raises a dark one.
            led_plain = (state_d == MATCH) && pol && (enter_match || led_q);
`ifdef RUN_DET_STICKY_EN
            led_d = led_q | led_plain;
`else
            led_d = led_plain;
`endif
            if (enter_match && pol) begin
                det_inc     = 1'b1;
                match_val_d = last_bit_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_bit_q  <= 1'b0;
            led_q       <= 1'b0;
            match_val_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_bit_q  <= last_bit_d;
            led_q       <= led_d;
            match_val_q <= match_val_d;
        end
    end

    assign led       = led_q;
    assign match_val = match_val_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Self-checking bench for run_length_detector (RUN_LEN=3; CNT_W=8 and CNT_W=2 instances).
module tb_run_length_detector;

    localparam int RUN_LEN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       signal = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       clear = 1'b0;
    logic       led, match_val, led2, match_val2;
    logic [7:0] det_cnt;
    logic [1:0] det_cnt2;

    int tests = 0;
    int fails = 0;
    bit cmp_on = 1'b0;

    // Model state: current run bit and its uncapped length since the last restart.
    logic m_bit = 1'b0;
    int   m_run = 0;
    logic m_led = 1'b0;
    logic m_mval = 1'b0;
    int   m_cnt = 0;
    int   m_cnt2 = 0;

    always #5 clk = ~clk;

    run_length_detector #(.RUN_LEN(RUN_LEN), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .signal(signal), .mode(mode), .clear(clear),
        .led(led), .match_val(match_val), .det_cnt(det_cnt)
    );

    run_length_detector #(.RUN_LEN(RUN_LEN), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .signal(signal), .mode(mode), .clear(clear),
        .led(led2), .match_val(match_val2), .det_cnt(det_cnt2)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bit  = 1'b0;
        m_run  = 0;
        m_led  = 1'b0;
        m_mval = 1'b0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    task automatic model_edge();
        logic pol;
        logic nl;
        if (rst) return;
        if (clear) begin
            model_reset();
        end else if (en) begin
            pol = signal ? mode[0] : mode[1];
            if (m_run == 0 || signal != m_bit) begin
                m_bit = signal;
                m_run = 1;
            end else begin
                m_run++;
            end
            if (m_run == RUN_LEN) begin
                nl = pol;
                if (pol) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                    m_mval = signal;
                end
            end else if (m_run > RUN_LEN) begin
                nl = m_led && pol;
            end else begin
                nl = 1'b0;
            end
`ifdef RUN_DET_STICKY_EN
            m_led = m_led | nl;
`else
            m_led = nl;
`endif
        end
    endtask

    always @(posedge clk) model_edge();

    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            chk("cyc_led", led, m_led);
            chk("cyc_mval", match_val, m_mval);
            chk("cyc_cnt", det_cnt, m_cnt);
            chk("cyc_led2", led2, m_led);
            chk("cyc_cnt2", det_cnt2, m_cnt2);
        end
    end

    task automatic step(input logic e, input logic s, input logic [1:0] md, input logic c);
        @(negedge clk);
        en = e;
        signal = s;
        mode = md;
        clear = c;
        @(posedge clk);
        #1;
        $display("[TB] t=%0t en=%0b sig=%0b mode=%0b clr=%0b -> led=%0b mval=%0b cnt=%0d cnt2=%0d",
                 $time, e, s, md, c, led, match_val, det_cnt, det_cnt2);
    endtask

    // Bits and expected led values are given LSB-first.
    task automatic seq(input string tag, input logic [1:0] md, input int n,
                       input logic [15:0] bits, input logic [15:0] leds);
        for (int i = 0; i < n; i++) begin
            step(1'b1, bits[i], md, 1'b0);
            chk($sformatf("%s_led%0d", tag, i), led, leds[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        chk("rst_led", led, 0);
        chk("rst_cnt", det_cnt, 0);
        chk("rst_mval", match_val, 0);
        @(negedge clk);
        rst = 1'b0;
        cmp_on = 1'b1;

        // 1: zeros run
        step(1'b0, 1'b0, 2'b10, 1'b1);
        seq("t1", 2'b10, 4, 16'b0000, 16'b1100);
        chk("t1_cnt", det_cnt, 1);
        chk("t1_mval", match_val, 0);

        // 2: ones run after an interruption
        step(1'b0, 1'b0, 2'b01, 1'b1);
        seq("t2", 2'b01, 6, 16'b111011, 16'b100000);
        chk("t2_cnt", det_cnt, 1);

        // 3: both polarities
        step(1'b0, 1'b0, 2'b11, 1'b1);
        seq("t3a", 2'b11, 3, 16'b000, 16'b100);
        chk("t3a_cnt", det_cnt, 1);
        chk("t3a_mval", match_val, 0);
        seq("t3b", 2'b11, 3, 16'b111, 16'b100);
        chk("t3b_cnt", det_cnt, 2);
        chk("t3b_mval", match_val, 1);

        // 4: en=0 samples are ignored
        step(1'b0, 1'b0, 2'b01, 1'b1);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 2'b01, 1'b0);
            chk("t4_hold", led, 0);
        end
        step(1'b1, 1'b1, 2'b01, 1'b0);
        chk("t4_led2", led, 0);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        chk("t4_led3", led, 1);

        // 5: saturation of the 2-bit counter
        step(1'b0, 1'b0, 2'b10, 1'b1);
        for (int r = 0; r < 5; r++) begin
            seq("t5", 2'b10, 4, 16'b1000, 16'b0100);
        end
        chk("t5_cnt2", det_cnt2, 3);
        chk("t5_cnt", det_cnt, 5);

        // Mode changes while in MATCH
        step(1'b0, 1'b0, 2'b10, 1'b1);
        seq("tm", 2'b10, 3, 16'b000, 16'b100);
        step(1'b1, 1'b0, 2'b00, 1'b0);
        chk("tm_drop", led, 0);
        step(1'b1, 1'b0, 2'b10, 1'b0);
        chk("tm_noraise", led, 0);
        chk("tm_cnt", det_cnt, 1);
        seq("tm2", 2'b10, 4, 16'b0001, 16'b1000);
        chk("tm2_cnt", det_cnt, 2);

        // 6: asynchronous reset mid-MATCH, then clear discards its sample
        step(1'b0, 1'b0, 2'b10, 1'b1);
        seq("t6", 2'b10, 3, 16'b000, 16'b100);
        @(negedge clk);
        en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_led", led, 0);
        chk("t6_rst_cnt", det_cnt, 0);
        model_reset();
        #1 rst = 1'b0;
        seq("t6b", 2'b10, 2, 16'b00, 16'b00);
        step(1'b1, 1'b0, 2'b10, 1'b1);
        chk("t6_clr_led", led, 0);
        seq("t6c", 2'b10, 3, 16'b000, 16'b100);
        step(1'b1, 1'b1, 2'b10, 1'b0);
`ifdef RUN_DET_STICKY_EN
        chk("t6_sticky", led, 1);
`else
        chk("t6_sticky", led, 0);
`endif
        step(1'b1, 1'b0, 2'b10, 1'b1);
        chk("t6_clr2", led, 0);

        // Pseudo-random soak checked by the per-cycle compare
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) signal = ~signal;
            step(($urandom_range(0, 3) != 0), signal,
                 (($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : mode),
                 ($urandom_range(0, 59) == 0));
        end

        @(negedge clk);
        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
